btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner_if.sv | 25 ++
 rtl/btn_conditioner.sv | 65 ++++++
 tb/tb_btn_conditioner.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/btn_conditioner_if.sv
// Button bundle between the raw push-button pins and the game logic.
// The conditioner sits on the slave side; whoever drives the raw buttons is the master.
interface btn_conditioner_if;
    logic [3:0] btn_in;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic       pause;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  pause
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output pause
    );
endinterface

// File: rtl/btn_conditioner.sv
// Four-button conditioner: two-flop synchronizer, per-button stability counter,
// registered press/release pulses and a pause flag toggled by btnS (bit 0).
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst,
    btn_conditioner_if.slave bus
);
    localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]            sync1_q, sync2_q;
    logic [3:0]            level_q, level_d;
    logic [3:0]            press_q, press_d;
    logic [3:0]            rel_q,   rel_d;
    logic                  pause_q, pause_d;
    logic [3:0][CNT_W-1:0] cnt_q,   cnt_d;

    // A counter only runs while the synchronized input disagrees with the
    // debounced level; any agreement restarts it, so short bounces vanish.
    always_comb begin
        level_d = level_q;
        press_d = '0;
        rel_d   = '0;
        cnt_d   = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    level_d[i] = sync2_q[i];
                    press_d[i] = sync2_q[i];
                    rel_d[i]   = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        pause_d = pause_q ^ press_q[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
            pause_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= bus.btn_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            pause_q <= pause_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = rel_q;
    assign bus.pause       = pause_q;
endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with DEBOUNCE_CYCLES=4: stimulus pushes
// expected output events, a negedge monitor pops them whenever a pulse or pause change appears.
module tb_btn_conditioner;
    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] level;
        logic       pause;
    } evt_t;

    logic clk;
    logic rst;
    int   cyc      = 0;
    int   checks   = 0;
    int   errors   = 0;
    logic prevPause = 1'b0;
    logic expPause  = 1'b0;
    evt_t expQ[$];

    btn_conditioner_if bus ();

    btn_conditioner #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    // Drives the buttons just after a rising edge and returns that edge's index
    task automatic applyStimulus(input logic [3:0] val, output int edgeIdx);
        @(posedge clk);
        #1;
        bus.btn_in = val;
        edgeIdx = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic pushExp(input int c, input logic [3:0] p, input logic [3:0] r,
                           input logic [3:0] l, input logic pz);
        evt_t ev;
        ev.cyc   = c;
        ev.press = p;
        ev.rel   = r;
        ev.level = l;
        ev.pause = pz;
        expQ.push_back(ev);
    endtask

    // Monitor: every visible output event must match the oldest expectation
    always @(negedge clk) begin
        evt_t ev;
        if (bus.btn_press != 4'b0 || bus.btn_release != 4'b0 || bus.pause != prevPause) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_event at cycle %0d: press=%b release=%b pause=%b, expected no event",
                         cyc, bus.btn_press, bus.btn_release, bus.pause);
            end else begin
                ev = expQ.pop_front();
                checkOutput("evt_cycle",   cyc,                  ev.cyc);
                checkOutput("evt_press",   int'(bus.btn_press),   int'(ev.press));
                checkOutput("evt_release", int'(bus.btn_release), int'(ev.rel));
                checkOutput("evt_level",   int'(bus.btn_level),   int'(ev.level));
                checkOutput("evt_pause",   int'(bus.pause),       int'(ev.pause));
            end
        end
        prevPause = bus.pause;
    end

    initial begin
        int e;
        int f;
        rst = 1'b1;
        bus.btn_in = 4'b0000;

        // Power-on reset, then the cycle after the last reset edge
        idle(3);
        @(negedge clk);
        checkOutput("reset_level",   int'(bus.btn_level),   0);
        checkOutput("reset_press",   int'(bus.btn_press),   0);
        checkOutput("reset_release", int'(bus.btn_release), 0);
        checkOutput("reset_pause",   int'(bus.pause),       0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_level", int'(bus.btn_level), 0);
        checkOutput("post_reset_pause", int'(bus.pause),     0);

        // Clean btnS press and release
        applyStimulus(4'b0001, e);
        pushExp(e + 6, 4'b0001, 4'b0000, 4'b0001, 1'b0);
        pushExp(e + 7, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        expPause = 1'b1;
        idle(20);
        applyStimulus(4'b0000, e);
        pushExp(e + 6, 4'b0000, 4'b0001, 4'b0000, expPause);
        idle(12);

        // Bounce on btnU: three high cycles, one low, repeated
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 4; j++) begin
                applyStimulus((j < 3) ? 4'b0010 : 4'b0000, e);
            end
            @(negedge clk);
            checkOutput("bounce_level", int'(bus.btn_level), 0);
        end
        idle(8);
        @(negedge clk);
        checkOutput("bounce_settled_level", int'(bus.btn_level), 0);

        // btnL held 20 cycles then released
        applyStimulus(4'b0100, e);
        pushExp(e + 6, 4'b0100, 4'b0000, 4'b0100, expPause);
        idle(19);
        applyStimulus(4'b0000, e);
        pushExp(e + 6, 4'b0000, 4'b0100, 4'b0000, expPause);
        idle(12);

        // btnL and btnR together
        applyStimulus(4'b1100, e);
        pushExp(e + 6, 4'b1100, 4'b0000, 4'b1100, expPause);
        idle(10);
        applyStimulus(4'b0000, e);
        pushExp(e + 6, 4'b0000, 4'b1100, 4'b0000, expPause);
        idle(12);

        // btnR held while reset hits mid-debounce; held press re-detected after reset
        applyStimulus(4'b1000, e);
        idle(3);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        f = cyc;
        checkOutput("mid_reset_edge", f, e + 4);
        if (expPause) pushExp(f, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        expPause = 1'b0;
        pushExp(f + 6, 4'b1000, 4'b0000, 4'b1000, expPause);
        idle(10);
        applyStimulus(4'b0000, e);
        pushExp(e + 6, 4'b0000, 4'b1000, 4'b0000, expPause);
        idle(12);

        // Two btnS presses 30 cycles apart: pause 0 -> 1 -> 0
        applyStimulus(4'b0001, e);
        pushExp(e + 6, 4'b0001, 4'b0000, 4'b0001, 1'b0);
        pushExp(e + 7, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        idle(9);
        applyStimulus(4'b0000, f);
        pushExp(f + 6, 4'b0000, 4'b0001, 4'b0000, 1'b1);
        idle(19);
        applyStimulus(4'b0001, f);
        checkOutput("second_press_spacing", f - e, 30);
        pushExp(f + 6, 4'b0001, 4'b0000, 4'b0001, 1'b1);
        pushExp(f + 7, 4'b0000, 4'b0000, 4'b0001, 1'b0);
        idle(9);
        applyStimulus(4'b0000, e);
        pushExp(e + 6, 4'b0000, 4'b0001, 4'b0000, 1'b0);
        idle(15);

        @(negedge clk);
        checkOutput("final_pause", int'(bus.pause), 0);
        checkOutput("pending_events", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
